spi_rx_buffer: RTL and testbench

SPI_RX_BUFFER -- requirements
Module: spi_rx_buffer

---
 rtl/spi_rx_buffer.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_rx_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_buffer.sv
// -----------------------------------------------------------------------------
// spi_rx_buffer
//
// SPI slave receiver with a byte-wide receive FIFO. The master drives its SPI
// clock from clk, so mosi is sampled directly on the rising edge of clk
// whenever cs is high. Bytes arrive LSB first. Each completed byte is pushed
// into a DEPTH-entry FIFO that the local side drains through rd_en/rd_data.
//
// Optional feature (compile-time macro SPI_RX_ECHO_EN):
//   defined   : miso echoes the previously completed byte of the current frame,
//               LSB first, one bit per edge (8'h00 before the first byte).
//   undefined : miso is tied to 0 and no echo storage exists.
//
// Parameters
//   DEPTH      number of FIFO entries (power of two, 2..16)
//
// Ports
//   clk        sole clock, serial inputs sampled on the rising edge
//   rst        asynchronous active-high reset
//   cs         frame select from the master, active-high
//   mosi       serial data from the master, LSB first
//   miso       serial data to the master (echo, see above)
//   rd_en      pop request for the oldest FIFO byte
//   rd_data    registered popped byte (holds between pops)
//   empty      FIFO holds no bytes
//   full       FIFO holds DEPTH bytes
//   count      number of bytes currently held
//   byte_valid one-cycle pulse per completed received byte
//   overflow   sticky: a completed byte was dropped because the FIFO was full
//   frame_err  one-cycle pulse when cs falls in the middle of a byte
//   clr_ovf    synchronous clear of overflow
// -----------------------------------------------------------------------------
module spi_rx_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     mosi,
    output logic                     miso,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     byte_valid,
    output logic                     overflow,
    output logic                     frame_err,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cs)  state_next = SHIFT;
            SHIFT:   if (!cs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit counter and shift register
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_reg;
    logic [2:0] bit_cnt_next;
    // Only bits 0..6 are stored; bit 7 is taken straight from mosi on the
    // completing edge so a byte is ready without an extra cycle.
    logic [6:0] shift_reg;
    logic [6:0] shift_next;

    logic       byte_done;
    logic [7:0] byte_in;

    assign byte_done    = cs && (bit_cnt_reg == 3'd7);
    assign byte_in      = {mosi, shift_reg};
    // 3-bit counter wraps 7->0 on its own, giving back-to-back bytes.
    assign bit_cnt_next = cs ? (bit_cnt_reg + 3'd1) : 3'd0;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_shift
            assign shift_next[gi] = !cs                        ? 1'b0 :
                                    (bit_cnt_reg == 3'(gi))    ? mosi :
                                                                 shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 7'd0;
        end else begin
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [7:0]    rd_data_reg;

    logic pop;
    logic push;
    logic drop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    // A pop on the completing edge frees a slot, so a full FIFO still
    // accepts the byte. An empty FIFO never pops, so only the push happens.
    assign pop  = rd_en && !empty;
    assign push = byte_done && (!full || pop);
    assign drop = byte_done && full && !pop;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= byte_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                rd_data_reg <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    logic byte_valid_reg;
    logic overflow_reg;
    logic frame_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= byte_done;
            frame_err_reg  <= !cs && (bit_cnt_reg != 3'd0);
            // A new drop wins over a simultaneous clear.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional echo on miso
    // ------------------------------------------------------------------
`ifdef SPI_RX_ECHO_EN
    logic [7:0] echo_reg;
    logic       miso_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_reg <= 8'h00;
            miso_reg <= 1'b0;
        end else if (!cs) begin
            // Each frame starts echoing zeros until its first byte lands.
            echo_reg <= 8'h00;
            miso_reg <= 1'b0;
        end else begin
            miso_reg <= echo_reg[bit_cnt_reg];
            if (byte_done) begin
                echo_reg <= byte_in;
            end
        end
    end

    assign miso = miso_reg;
`else
    assign miso = 1'b0;
`endif

    assign rd_data    = rd_data_reg;
    assign count      = count_reg;
    assign byte_valid = byte_valid_reg;
    assign overflow   = overflow_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_spi_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_buffer
//
// Directed bench for spi_rx_buffer. A queue-based reference model tracks the
// bytes the receiver should hold; a compare process checks every DUT output
// against it on each falling clock edge, and literal expectations at key
// points pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_rx_buffer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic       mosi = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       miso;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       byte_valid;
    logic       overflow;
    logic       frame_err;

    int checks = 0;
    int failures = 0;

    // Reference model state
    byte unsigned q[$];
    int           nbits = 0;
    int           acc = 0;
    logic [7:0]   m_rd = 8'h00;
    logic         m_bv = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_fe = 1'b0;

    spi_rx_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .byte_valid (byte_valid),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        nbits = 0;
        acc   = 0;
        m_rd  = 8'h00;
        m_bv  = 1'b0;
        m_ovf = 1'b0;
        m_fe  = 1'b0;
    endtask

    // Behaviour of one clock edge given the inputs that edge sampled.
    task automatic model_edge();
        bit         was_full;
        bit         do_pop;
        bit         done;
        logic [7:0] b;
        was_full = (q.size() == DEPTH);
        do_pop   = rd_en && (q.size() != 0);
        done     = 1'b0;
        b        = 8'h00;
        m_fe     = 1'b0;
        if (cs) begin
            acc = acc + (int'(mosi) << nbits);
            nbits++;
            if (nbits == 8) begin
                done  = 1'b1;
                b     = acc[7:0];
                nbits = 0;
                acc   = 0;
            end
        end else begin
            if (nbits != 0) m_fe = 1'b1;
            nbits = 0;
            acc   = 0;
        end
        m_bv = done;
        if (do_pop) m_rd = q.pop_front();
        if (done && (!was_full || do_pop)) q.push_back(b);
        if (done && was_full && !do_pop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("count",      int'(count),      q.size());
        check("empty",      int'(empty),      int'(q.size() == 0));
        check("full",       int'(full),       int'(q.size() == DEPTH));
        check("rd_data",    int'(rd_data),    int'(m_rd));
        check("byte_valid", int'(byte_valid), int'(m_bv));
        check("overflow",   int'(overflow),   int'(m_ovf));
        check("frame_err",  int'(frame_err),  int'(m_fe));
        check("miso",       int'(miso),       0);
    end

    task automatic step(input logic c, input logic m, input logic r, input logic clr);
        cs      = c;
        mosi    = m;
        rd_en   = r;
        clr_ovf = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pop_last);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, b[i], pop_last && (i == 7), 1'b0);
        end
    endtask

    initial begin
        // Reset
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_rd_data", int'(rd_data), 8'h00);
        step(0, 0, 0, 0);

        // Single byte A5
        send_byte(8'hA5, 1'b0);
        check("a5_byte_valid", int'(byte_valid), 1);
        check("a5_count", int'(count), 1);
        step(0, 0, 1, 0);
        check("a5_pop", int'(rd_data), 8'hA5);
        check("a5_empty", int'(empty), 1);

        // Back-to-back bytes in one frame
        send_byte(8'h3C, 1'b0);
        check("b2b_first_valid", int'(byte_valid), 1);
        send_byte(8'hC3, 1'b0);
        check("b2b_second_valid", int'(byte_valid), 1);
        check("b2b_count", int'(count), 2);
        step(0, 0, 1, 0);
        check("b2b_pop0", int'(rd_data), 8'h3C);
        step(0, 0, 1, 0);
        check("b2b_pop1", int'(rd_data), 8'hC3);

        // Overflow: nine bytes, no pops
        for (int k = 1; k <= 9; k++) send_byte(8'(k), 1'b0);
        step(0, 0, 0, 0);
        check("ovf_full", int'(full), 1);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_count", int'(count), 8);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1, 0);
            check("ovf_pop", int'(rd_data), k);
        end
        step(0, 0, 1, 0);
        check("empty_pop_hold", int'(rd_data), 8'h08);
        check("empty_pop_empty", int'(empty), 1);
        check("ovf_still_set", int'(overflow), 1);
        step(0, 0, 0, 1);
        check("ovf_cleared", int'(overflow), 0);

        // Aborted frame after 5 bits
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("abort_frame_err", int'(frame_err), 1);
        check("abort_count", int'(count), 0);
        step(0, 0, 0, 0);
        check("abort_pulse_end", int'(frame_err), 0);
        send_byte(8'h5A, 1'b0);
        step(0, 0, 1, 0);
        check("abort_next_byte", int'(rd_data), 8'h5A);

        // Simultaneous push and pop at full
        for (int k = 0; k < 8; k++) send_byte(8'h10 + 8'(k), 1'b0);
        check("pp_full", int'(full), 1);
        send_byte(8'h18, 1'b1);
        check("pp_count", int'(count), 8);
        check("pp_no_ovf", int'(overflow), 0);
        check("pp_rd_data", int'(rd_data), 8'h10);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1, 0);
            check("pp_drain", int'(rd_data), 8'h10 + k);
        end

        // Reset mid-frame with two bytes held
        send_byte(8'h21, 1'b0);
        send_byte(8'h42, 1'b0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        check("mid_count_before", int'(count), 2);
        #2;
        rst = 1'b1;
        cs  = 1'b0;
        model_reset();
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_rd_data", int'(rd_data), 8'h00);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        step(0, 0, 0, 0);
        send_byte(8'hFF, 1'b0);
        step(0, 0, 1, 0);
        check("mid_next_byte", int'(rd_data), 8'hFF);
        step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
